inst_fetch_ctrl: RTL and testbench

Fetch sequencer between the PC generator/branch predictor and the instruction memory port. It owns the fetch PC and issues instruction-memory requests under a credit limit. It tracks in-flight requests, discards stale responses after any redirect, and buffers returned instructions in a small FIFO. That FIFO feeds `inst_valid/inst_pc/inst` to the PC generator, pre-decoder and decode stage.

---
 rtl/inst_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues credited imem requests,
// drops stale responses after redirects and buffers instructions.
module inst_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUTST  = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [ADDR_WIDTH-1:0] BOOT_ADDR,
  input  logic                  fetch_en,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] inst,
  input  logic                  inst_ready
);

  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_WIDTH:0] DEPTH_C =
    (CNT_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] OUTST_C =
    CNT_WIDTH'(MAX_OUTST);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M =
    {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  infl_q, infl_d;
  logic [CNT_WIDTH-1:0]  kill_q, kill_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [QW-1:0]         qwr_q, qwr_d, qrd_q, qrd_d;
  logic [FW-1:0]         fwr_q, fwr_d, frd_q, frd_d;
  logic [ADDR_WIDTH-1:0] qpc_q  [MAX_OUTST];
  logic [ADDR_WIDTH-1:0] fpc_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fdat_q [FIFO_DEPTH];

  logic                  req_hs, rsp, pop, redir, push;
  logic [CNT_WIDTH:0]    credit;
  logic [ADDR_WIDTH-1:0] tgt;

  function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTST-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FW-1:0] fnext(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign credit = {1'b0, infl_q} + {1'b0, cnt_q};
  assign imem_req_valid = (state_q == RUN) && (credit < DEPTH_C)
                          && (infl_q < OUTST_C);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (cnt_q != '0);
  assign inst_pc        = fpc_q[frd_q];
  assign inst           = fdat_q[frd_q];

  assign req_hs = imem_req_valid && imem_req_ready;
  assign rsp    = imem_rsp_valid;
  assign pop    = inst_valid && inst_ready;
  assign redir  = redir_valid || (pred_valid && pop);
  assign tgt    = redir_valid ? redir_pc : pred_pc;
  // Responses in a redirect cycle are stale by definition.
  assign push   = rsp && (kill_q == '0) && !redir;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fetch_en) state_d = RUN;
      RUN:  if (!fetch_en) state_d = HALT;
      HALT: begin
        if (fetch_en) state_d = RUN;
        else if (infl_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    infl_d = infl_q + CNT_WIDTH'(req_hs) - CNT_WIDTH'(rsp);
    kill_d = kill_q;
    cnt_d  = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    qwr_d  = req_hs ? qnext(qwr_q) : qwr_q;
    qrd_d  = rsp ? qnext(qrd_q) : qrd_q;
    fwr_d  = push ? fnext(fwr_q) : fwr_q;
    frd_d  = pop ? fnext(frd_q) : frd_q;
    if (req_hs) pc_d = pc_q + ADDR_WIDTH'(4);
    if (rsp && kill_q != '0) kill_d = kill_q - 1'b1;
    if (redir) begin
      pc_d   = tgt & ALIGN_M;
      kill_d = infl_d;
      cnt_d  = '0;
      fwr_d  = '0;
      frd_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      infl_q  <= '0;
      kill_q  <= '0;
      cnt_q   <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
      fwr_q   <= '0;
      frd_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]  <= '0;
        fdat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
      fwr_q   <= fwr_d;
      frd_q   <= frd_d;
      if (push) begin
        fpc_q[fwr_q]  <= qpc_q[qrd_q];
        fdat_q[fwr_q] <= imem_rsp_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (req_hs) qpc_q[qwr_q] <= pc_q;
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: 1-cycle stallable memory model
// and an expected-PC scoreboard checked on every output handshake.
module tb_inst_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic [31:0] BOOT_ADDR = 32'h0000_1000;
  logic        fetch_en, redir_valid, pred_valid;
  logic [31:0] redir_pc, pred_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  int n0;
  bit stall = 1'b0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  always #5 CLK = ~CLK;

  inst_fetch_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .BOOT_ADDR(BOOT_ADDR),
    .fetch_en(fetch_en),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst),
    .inst_ready(inst_ready)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drive_rsp();
    imem_rsp_valid = !stall && (mq.size() != 0);
    imem_rsp_data  = (mq.size() != 0) ? f(mq[0]) : 32'h0;
  endtask

  // One clock: sample the coming edge's handshakes, then model it.
  task automatic cyc(input bit rd = 1'b0,
                     input logic [31:0] nb = 32'h0);
    logic hs, rv, ohs;
    logic [31:0] a, opc, oin, e;
    hs  = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rv  = imem_rsp_valid;
    ohs = inst_valid && inst_ready;
    opc = inst_pc;
    oin = inst;
    @(negedge CLK);
    if (rv && mq.size() != 0) void'(mq.pop_front());
    if (hs) begin
      mq.push_back(a);
      req_log.push_back(a);
      chk("outstanding", 32'(mq.size() <= 2), 32'd1);
    end
    if (ohs) begin
      n_out++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("out_pc", opc, e);
      chk("out_inst", oin, f(e));
    end
    if (rd) set_exp(nb);
    drive_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    fetch_en = 0; redir_valid = 0; redir_pc = 0;
    pred_valid = 0; pred_pc = 0;
    imem_req_ready = 1; inst_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = 0;
    #1 RSTN = 1'b0;
    #11;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_req_addr", imem_req_addr, 32'h1000);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(); cyc();
    chk("idle_noreq", imem_req_valid, 0);

    // boot
    fetch_en = 1;
    set_exp(32'h1000);
    req_log.delete();
    cyc();
    chk("boot_req_valid", imem_req_valid, 1);
    chk("boot_req_addr", imem_req_addr, 32'h1000);
    cyc();
    chk("boot_lat0", inst_valid, 0);
    cyc();
    chk("boot_lat1", inst_valid, 1);
    chk("boot_pc", inst_pc, 32'h1000);
    repeat (12) cyc();
    for (int i = 0; i < 4; i++)
      chk("boot_seq", req_log[i], 32'h1000 + 32'(4 * i));
    chk("boot_outs", 32'(n_out >= 6), 32'd1);

    // backpressure
    inst_ready = 0;
    req_log.delete();
    repeat (5) cyc();
    chk("bp_reqs", 32'(req_log.size() <= 2), 32'd1);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_inst_valid", inst_valid, 1);
    chk("bp_inflight", 32'(mq.size()), 32'd0);
    inst_ready = 1;
    n0 = n_out;
    repeat (8) cyc();
    chk("bp_drain", 32'(n_out - n0 >= 2), 32'd1);

    // backend redirect with two in flight
    stall = 1; drive_rsp();
    repeat (6) cyc();
    chk("rd_inflight", 32'(mq.size()), 32'd2);
    chk("rd_noreq", imem_req_valid, 0);
    stall = 0; drive_rsp();
    redir_valid = 1; redir_pc = 32'h2002;
    cyc(1'b1, 32'h2000);
    redir_valid = 0;
    chk("rd_addr", imem_req_addr, 32'h2000);
    chk("rd_req_valid", imem_req_valid, 1);
    chk("rd_inst_valid", inst_valid, 0);
    n0 = n_out;
    repeat (8) cyc();
    chk("rd_outs", 32'(n_out > n0), 32'd1);

    // redirect beats prediction
    redir_valid = 1; redir_pc = 32'h4000;
    pred_valid = 1; pred_pc = 32'h3000;
    cyc(1'b1, 32'h4000);
    redir_valid = 0; pred_valid = 0;
    chk("pr_addr", imem_req_addr, 32'h4000);
    chk("pr_inst_valid", inst_valid, 0);
    repeat (6) cyc();

    // prediction on an output handshake
    for (int i = 0; i < 10 && !inst_valid; i++) cyc();
    chk("pp_wait", inst_valid, 1);
    pred_valid = 1; pred_pc = 32'h3000;
    cyc(1'b1, 32'h3000);
    pred_valid = 0;
    chk("pp_addr", imem_req_addr, 32'h3000);
    chk("pp_inst_valid", inst_valid, 0);
    n0 = n_out;
    repeat (8) cyc();
    chk("pp_outs", 32'(n_out > n0), 32'd1);

    // halt with two in flight
    stall = 1; drive_rsp();
    for (int i = 0; i < 8 && mq.size() < 2; i++) cyc();
    chk("h_inflight", 32'(mq.size()), 32'd2);
    fetch_en = 0;
    cyc();
    chk("h_noreq0", imem_req_valid, 0);
    repeat (2) cyc();
    chk("h_noreq1", imem_req_valid, 0);
    n0 = n_out;
    stall = 0; drive_rsp();
    repeat (5) cyc();
    chk("h_delivered", 32'(n_out - n0), 32'd2);
    chk("h_idle", imem_req_valid, 0);

    // wrap
    redir_valid = 1; redir_pc = 32'hFFFF_FFFC;
    cyc(1'b1, 32'hFFFF_FFFC);
    redir_valid = 0;
    chk("w_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("w_idle", imem_req_valid, 0);
    fetch_en = 1;
    req_log.delete();
    repeat (8) cyc();
    chk("w_req0", req_log[0], 32'hFFFF_FFFC);
    chk("w_req1", req_log[1], 32'h0000_0000);

    // asynchronous reset mid-stream
    #2 RSTN = 1'b0;
    imem_rsp_valid = 0;
    #1;
    chk("mr_req_valid", imem_req_valid, 0);
    chk("mr_inst_valid", inst_valid, 0);
    chk("mr_inst_pc", inst_pc, 0);
    chk("mr_inst", inst, 0);
    chk("mr_req_addr", imem_req_addr, 32'h1000);
    mq.delete(); exp_q.delete();
    fetch_en = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();
    chk("post_req_valid", imem_req_valid, 0);
    chk("post_inst_valid", inst_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
